// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline datapath.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Register $zero: hardwired to zero, never written.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_mux.sv
// Write-back data select: memory read data for loads, ALU result otherwise.
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data
);

    // Pure select, independent of any write enable.
    always_comb begin
        write_data = mem_to_reg ? read_data : alu_result;
    end

endmodule

// File: rtl/wb_register_file.sv
// Write-back stage plus architectural register file: two write ports
// (primary wins on collision), two bypassed ID read ports and a
// registered debug read port.
module wb_register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              WB_RegWrite,
    input  logic              WB_MemtoReg,
    input  logic [DATA_W-1:0] WB_ReadData,
    input  logic [DATA_W-1:0] WB_ALUResult,
    input  logic [ADDR_W-1:0] WB_RegDstData,
    input  logic              WB_RegWrite2,
    input  logic [ADDR_W-1:0] WB_RegDst2Data,
    input  logic [ADDR_W-1:0] ID_ReadReg1,
    input  logic [ADDR_W-1:0] ID_ReadReg2,
    output logic [DATA_W-1:0] ID_ReadData1,
    output logic [DATA_W-1:0] ID_ReadData2,
    output logic [DATA_W-1:0] WB_WriteData,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData
);

    localparam int                NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RZERO = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0]            dbg_q, dbg_d;
    logic                         wr1_en, wr2_en;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .mem_to_reg (WB_MemtoReg),
        .read_data  (WB_ReadData),
        .alu_result (WB_ALUResult),
        .write_data (WB_WriteData)
    );

    // Effective enables: writes aimed at $zero are dropped outright.
    always_comb begin
        wr1_en = WB_RegWrite  && (WB_RegDstData  != RZERO);
        wr2_en = WB_RegWrite2 && (WB_RegDst2Data != RZERO);
    end

    // Next register state; primary applied last so it wins a collision.
    always_comb begin
        regs_d = regs_q;
        if (wr2_en) regs_d[WB_RegDst2Data] = WB_ALUResult;
        if (wr1_en) regs_d[WB_RegDstData]  = WB_WriteData;
        regs_d[RZERO] = '0;
    end

    // Debug port sees stored state only, never the in-flight write.
    always_comb begin
        dbg_d = regs_q[DbgAddr];
    end

    // Bypassed read: in-flight primary, then secondary, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0]            idx,
        input logic                         w1,
        input logic [ADDR_W-1:0]            d1,
        input logic [DATA_W-1:0]            v1,
        input logic                         w2,
        input logic [ADDR_W-1:0]            d2,
        input logic [DATA_W-1:0]            v2,
        input logic [NREGS-1:0][DATA_W-1:0] regs
    );
        if (idx == RZERO)          return '0;
        else if (w1 && d1 == idx)  return v1;
        else if (w2 && d2 == idx)  return v2;
        else                       return regs[idx];
    endfunction

    // ID read ports, combinational with write-to-read bypass.
    always_comb begin
        ID_ReadData1 = read_port(ID_ReadReg1, wr1_en, WB_RegDstData, WB_WriteData,
                                 wr2_en, WB_RegDst2Data, WB_ALUResult, regs_q);
        ID_ReadData2 = read_port(ID_ReadReg2, wr1_en, WB_RegDstData, WB_WriteData,
                                 wr2_en, WB_RegDst2Data, WB_ALUResult, regs_q);
    end

    // Storage and debug register; Clr wipes both without waiting for Clk.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            regs_q <= '0;
            dbg_q  <= '0;
        end else begin
            regs_q <= regs_d;
            dbg_q  <= dbg_d;
        end
    end

    assign DbgData = dbg_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_wb_register_file;

    logic        Clk, Clr;
    logic        WB_RegWrite, WB_MemtoReg, WB_RegWrite2;
    logic [31:0] WB_ReadData, WB_ALUResult;
    logic [4:0]  WB_RegDstData, WB_RegDst2Data, ID_ReadReg1, ID_ReadReg2, DbgAddr;
    logic [31:0] ID_ReadData1, ID_ReadData2, WB_WriteData, DbgData;

    wb_register_file dut (
        .Clk(Clk), .Clr(Clr),
        .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult),
        .WB_RegDstData(WB_RegDstData), .WB_RegWrite2(WB_RegWrite2),
        .WB_RegDst2Data(WB_RegDst2Data),
        .ID_ReadReg1(ID_ReadReg1), .ID_ReadReg2(ID_ReadReg2),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .WB_WriteData(WB_WriteData), .DbgAddr(DbgAddr), .DbgData(DbgData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of architectural values plus debug value.
    logic [31:0] mdl [32];
    logic [31:0] mdl_dbg;

    typedef struct {
        logic        we;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        we2;
        logic [4:0]  dst2;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] expwd;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_wd();
        return WB_MemtoReg ? WB_ReadData : WB_ALUResult;
    endfunction

    // What ID should see for register r given the current inputs.
    function automatic logic [31:0] mdl_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (WB_RegWrite && WB_RegDstData == r) return mdl_wd();
        if (WB_RegWrite2 && WB_RegDst2Data == r) return WB_ALUResult;
        return mdl[r];
    endfunction

    // One rising edge; model commits the same write the inputs request.
    task automatic cyc();
        @(posedge Clk);
        mdl_dbg = mdl[DbgAddr];
        if (WB_RegWrite2 && WB_RegDst2Data != 0) mdl[WB_RegDst2Data] = WB_ALUResult;
        if (WB_RegWrite && WB_RegDstData != 0)   mdl[WB_RegDstData]  = mdl_wd();
        #1;
    endtask

    task automatic idle();
        WB_RegWrite = 0; WB_RegWrite2 = 0; WB_MemtoReg = 0;
        WB_ReadData = 0; WB_ALUResult = 0; WB_RegDstData = 0; WB_RegDst2Data = 0;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl_dbg = 32'h0;
    endtask

    task automatic add(input logic we, input logic m2r, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] dst,
                       input logic we2, input logic [4:0] dst2,
                       input logic [4:0] rr1, input logic [4:0] rr2,
                       input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ewd);
        vec_t v;
        v.we = we; v.m2r = m2r; v.rd = rd; v.alu = alu; v.dst = dst;
        v.we2 = we2; v.dst2 = dst2; v.rr1 = rr1; v.rr2 = rr2;
        v.exp1 = e1; v.exp2 = e2; v.expwd = ewd;
        vecs.push_back(v);
    endtask

    initial begin
        mdl_clear();
        idle();
        Clr = 1'b1; ID_ReadReg1 = 5'd0; ID_ReadReg2 = 5'd0; DbgAddr = 5'd0;

        // Directed vectors, applied in order from the post-reset state.
        //   we m2r rd            alu           dst we2 dst2 rr1 rr2  exp1          exp2          expwd
        add(1, 1, 32'h12345678, 32'hFFFFFFFF, 8,  0, 0,  8,  0,  32'h12345678, 32'h0,        32'h12345678);
        add(0, 0, 32'h0,        32'h0,        0,  0, 0,  8,  8,  32'h12345678, 32'h12345678, 32'h0);
        add(1, 0, 32'h0,        32'hAAAA5555, 0,  0, 0,  0,  0,  32'h0,        32'h0,        32'hAAAA5555);
        add(0, 0, 32'h0,        32'h0,        0,  0, 0,  0,  8,  32'h0,        32'h12345678, 32'h0);
        add(1, 1, 32'h11,       32'h400,      4,  1, 31, 4,  31, 32'h11,       32'h400,      32'h11);
        add(0, 0, 32'h0,        32'h0,        0,  0, 0,  4,  31, 32'h11,       32'h400,      32'h0);
        add(1, 1, 32'h1,        32'h2,        9,  1, 9,  9,  9,  32'h1,        32'h1,        32'h1);
        add(0, 0, 32'h0,        32'h0,        0,  0, 0,  9,  8,  32'h1,        32'h12345678, 32'h0);
        add(0, 0, 32'h0,        32'h77,       0,  1, 0,  0,  8,  32'h0,        32'h12345678, 32'h77);
        add(1, 0, 32'h0,        32'h5,        3,  0, 0,  3,  9,  32'h5,        32'h1,        32'h5);
        add(0, 0, 32'h0,        32'h0,        0,  0, 0,  3,  4,  32'h5,        32'h11,       32'h0);

        // Reset state while Clr is held.
        #12;
        ID_ReadReg1 = 5'd8; ID_ReadReg2 = 5'd31;
        #1;
        chk("reset_rd1", ID_ReadData1, 32'h0);
        chk("reset_rd2", ID_ReadData2, 32'h0);
        chk("reset_dbg", DbgData, 32'h0);
        Clr = 1'b0;
        @(posedge Clk); #1;

        foreach (vecs[i]) begin
            WB_RegWrite = vecs[i].we;  WB_MemtoReg = vecs[i].m2r;
            WB_ReadData = vecs[i].rd;  WB_ALUResult = vecs[i].alu;
            WB_RegDstData = vecs[i].dst; WB_RegWrite2 = vecs[i].we2;
            WB_RegDst2Data = vecs[i].dst2;
            ID_ReadReg1 = vecs[i].rr1; ID_ReadReg2 = vecs[i].rr2;
            #1;
            chk($sformatf("vec%0d_rd1", i), ID_ReadData1, vecs[i].exp1);
            chk($sformatf("vec%0d_rd2", i), ID_ReadData2, vecs[i].exp2);
            chk($sformatf("vec%0d_wd", i),  WB_WriteData, vecs[i].expwd);
            cyc();
        end
        idle();

        // Debug port on r0 after a write attempt to r0.
        DbgAddr = 5'd0;
        cyc();
        chk("dbg_r0", DbgData, 32'h0);

        // Bypass vs stale debug: r3 holds 5, overwrite with 7.
        DbgAddr = 5'd3;
        cyc();
        chk("dbg_r3_old", DbgData, 32'h5);
        WB_RegWrite = 1; WB_MemtoReg = 0; WB_ALUResult = 32'h7; WB_RegDstData = 5'd3;
        ID_ReadReg2 = 5'd3;
        #1;
        chk("byp_rd2_r3", ID_ReadData2, 32'h7);
        chk("dbg_r3_pre", DbgData, 32'h5);
        cyc();
        idle();
        #1;
        chk("rd2_r3_stored", ID_ReadData2, 32'h7);
        chk("dbg_r3_lag", DbgData, 32'h5);
        cyc();
        chk("dbg_r3_new", DbgData, 32'h7);

        // Mid-cycle Clr wipes storage and debug without a clock edge.
        WB_RegWrite = 1; WB_MemtoReg = 0; WB_ALUResult = 32'hDEADBEEF; WB_RegDstData = 5'd5;
        DbgAddr = 5'd5;
        cyc();
        idle();
        cyc();
        ID_ReadReg1 = 5'd5;
        #1;
        chk("pre_clr_rd1", ID_ReadData1, 32'hDEADBEEF);
        chk("pre_clr_dbg", DbgData, 32'hDEADBEEF);
        Clr = 1'b1;
        #1;
        chk("clr_rd1", ID_ReadData1, 32'h0);
        chk("clr_dbg", DbgData, 32'h0);
        ID_ReadReg1 = 5'd4;
        #1;
        chk("clr_rd1_r4", ID_ReadData1, 32'h0);
        Clr = 1'b0;
        mdl_clear();
        cyc();

        // Randomized traffic against the model; small index range forces
        // collisions and back-to-back writes to the same register.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] lim;
            lim = (n < 200) ? 5'd7 : 5'd31;
            WB_RegWrite    = ($urandom_range(0, 3) != 0);
            WB_RegWrite2   = ($urandom_range(0, 2) == 0);
            WB_MemtoReg    = $urandom_range(0, 1);
            WB_ReadData    = $urandom;
            WB_ALUResult   = $urandom;
            WB_RegDstData  = 5'($urandom_range(0, lim));
            WB_RegDst2Data = 5'($urandom_range(0, lim));
            ID_ReadReg1    = 5'($urandom_range(0, lim));
            ID_ReadReg2    = 5'($urandom_range(0, lim));
            DbgAddr        = 5'($urandom_range(0, lim));
            #1;
            chk("rnd_rd1", ID_ReadData1, mdl_read(ID_ReadReg1));
            chk("rnd_rd2", ID_ReadData2, mdl_read(ID_ReadReg2));
            chk("rnd_wd",  WB_WriteData, mdl_wd());
            cyc();
            chk("rnd_dbg", DbgData, mdl_dbg);
        end

        // Final sweep of stored contents through the debug port.
        idle();
        for (int r = 0; r < 32; r++) begin
            DbgAddr = 5'(r);
            cyc();
            chk("sweep_dbg", DbgData, mdl[r]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
